// File: rtl/skid_buffer_stream.sv
// Two-entry register slice for a valid/ready stream. Every output (s_ready, m_valid, m_data)
// comes straight from a flop, so no combinational path crosses the slice in either direction,
// and one word per cycle still flows while the downstream accepts.
module skid_buffer_stream #(
  parameter int unsigned           WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data
);

  // StEmpty: no word held; StBusy: out_reg holds a word; StFull: out_reg and skid_reg hold words.
  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e                state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [WORD_WIDTH-1:0] out_q, out_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  s_xfer, m_xfer;

  assign s_xfer  = s_valid & s_ready_q;
  assign m_xfer  = m_valid_q & m_ready;

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = out_q;

  // Next state, data-register updates, and the registered handshake flags derived from them.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (clear) begin
      // Flush wins over any transfer on the same edge.
      state_d = StEmpty;
      out_d   = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (s_xfer) begin
            out_d   = s_data;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (s_xfer && !m_xfer) begin
            skid_d  = s_data;
            state_d = StFull;
          end else if (!s_xfer && m_xfer) begin
            state_d = StEmpty;
          end else if (s_xfer && m_xfer) begin
            out_d   = s_data;
          end
        end
        StFull: begin
          // s_ready is low here, so only the downstream side can move.
          if (m_xfer) begin
            out_d   = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    s_ready_d = (state_d != StFull);
    m_valid_d = (state_d != StEmpty);
  end

  // Control state and handshake flags; s_ready stays low in reset and rises on the first edge after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Data registers: output word and the skid word parked while the downstream stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

endmodule
